// File: rtl/bus_pkg.sv
// Shared definitions for the two-master system bus: FSM state encoding and
// the fixed bit values that appear on the serial lines.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SEL,
        ADDR,
        WDATA,
        RWAIT,
        RDATA,
        DONE
    } state_t;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;
    localparam logic SEL_START  = 1'b1;

endpackage

// File: rtl/bus_serialiser.sv
// Generic LSB-first load/shift register with a bit counter; last flags the
// bit currently presented (or being captured) as the final one of len bits.
module bus_serialiser #(
    parameter int W = 8,
    localparam int CW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic [CW-1:0] len,
    input  logic          shift,
    input  logic          shift_in,
    output logic [W-1:0]  data,
    output logic          last
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (shift) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shift data carries no reset; consumers gate it with their own enables.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= {shift_in, data[W-1:1]};
        end
    end

    assign last = (cnt == len - 1'b1);

endmodule

// File: rtl/bus_master_port.sv
// Master-side bus port: requests the bus, serialises slave select, mode,
// address and write data, captures serial read data and returns one response.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int SLV_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [SLV_W-1:0]  cmd_slave,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_request,
    input  logic              bus_grant,
    output logic              slave_select,
    output logic              m_tx,
    output logic              m_tx_valid,
    input  logic              m_rx,
    input  logic              m_rx_valid,
    output logic              busy
);

    localparam int SEL_W  = 1 + SLV_W;
    localparam int TX_W   = (1 + ADDR_W > DATA_W) ? 1 + ADDR_W : DATA_W;
    localparam int SEL_CW = $clog2(SEL_W) + 1;
    localparam int TX_CW  = $clog2(TX_W) + 1;
    localparam int RX_CW  = $clog2(DATA_W) + 1;
    localparam int TMO_W  = $clog2(TIMEOUT) + 1;

    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [SEL_CW-1:0] SEL_LEN  = SEL_CW'(SEL_W);
    localparam logic [TX_CW-1:0]  ADDR_LEN = TX_CW'(1 + ADDR_W);
    localparam logic [TX_CW-1:0]  DATA_LEN = TX_CW'(DATA_W);
    localparam logic [RX_CW-1:0]  RX_LEN   = RX_CW'(DATA_W);

    state_t              state;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                req_q;
    logic                sel_en;

    logic                lat_write;
    logic [SLV_W-1:0]    lat_slave;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    logic                sel_load, sel_shift, sel_last;
    logic [SEL_W-1:0]    sel_q;
    logic                tx_load, tx_shift, tx_last;
    logic [TX_W-1:0]     tx_load_data, tx_q;
    logic [TX_CW-1:0]    tx_len;
    logic                rx_load, rx_shift, rx_last;
    logic [DATA_W-1:0]   rx_q, rx_next;

    logic                fin, fin_err;
    logic                mode_bit;
    logic                unused_bits;

    assign mode_bit = lat_write ? MODE_WRITE : MODE_READ;
    assign rx_next  = {m_rx, rx_q[DATA_W-1:1]};

    // Serialiser sequencing: each phase loads its register on the cycle it is entered.
    always_comb begin
        sel_load     = (state == REQ) && bus_grant;
        sel_shift    = (state == SEL);
        tx_load      = 1'b0;
        tx_load_data = TX_W'(lat_wdata);
        tx_len       = (state == WDATA) ? DATA_LEN : ADDR_LEN;
        tx_shift     = (state == ADDR) || (state == WDATA);
        rx_load      = 1'b0;
        rx_shift     = ((state == RWAIT) || (state == RDATA)) && m_rx_valid && bus_grant;
        if ((state == SEL) && bus_grant && sel_last) begin
            tx_load      = 1'b1;
            tx_load_data = TX_W'({lat_addr, mode_bit});
        end
        if ((state == ADDR) && bus_grant && tx_last) begin
            tx_load = lat_write;
            rx_load = !lat_write;
        end
    end

    // Completion decision: grant loss in SEL..RDATA aborts in the same cycle.
    always_comb begin
        fin     = 1'b0;
        fin_err = 1'b0;
        case (state)
            REQ: begin
                if (!bus_grant && (tmo_cnt == TMO_LAST)) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            SEL, ADDR: begin
                if (!bus_grant) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            WDATA: begin
                if (!bus_grant) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (tx_last) begin
                    fin = 1'b1;
                end
            end
            RWAIT, RDATA: begin
                if (!bus_grant) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (m_rx_valid) begin
                    fin = rx_last;
                end else if (tmo_cnt == TMO_LAST) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: begin
                fin     = 1'b0;
                fin_err = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            req_q      <= 1'b0;
            sel_en     <= 1'b0;
            m_tx_valid <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else if (fin) begin
            state      <= DONE;
            req_q      <= 1'b0;
            sel_en     <= 1'b0;
            m_tx_valid <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_err    <= fin_err;
            rsp_rdata  <= (fin_err || lat_write) ? '0 : rx_next;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= REQ;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        req_q     <= 1'b1;
                        tmo_cnt   <= '0;
                    end
                end
                REQ: begin
                    if (bus_grant) begin
                        state   <= SEL;
                        sel_en  <= 1'b1;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SEL: begin
                    if (sel_last) begin
                        state      <= ADDR;
                        sel_en     <= 1'b0;
                        m_tx_valid <= 1'b1;
                    end
                end
                ADDR: begin
                    if (tx_last) begin
                        if (lat_write) begin
                            state <= WDATA;
                        end else begin
                            state      <= RWAIT;
                            m_tx_valid <= 1'b0;
                            tmo_cnt    <= '0;
                        end
                    end
                end
                WDATA: ;
                RWAIT, RDATA: begin
                    if (m_rx_valid) begin
                        state   <= RDATA;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == IDLE) && cmd_valid) begin
            lat_write <= cmd_write;
            lat_slave <= cmd_slave;
            lat_addr  <= cmd_addr;
            lat_wdata <= cmd_wdata;
        end
    end

    // Request rises in the accept cycle so back-to-back transactions leave only DONE low.
    assign bus_request  = req_q | (cmd_valid & cmd_ready & ~reset);
    assign slave_select = sel_en & sel_q[0];
    assign m_tx         = m_tx_valid & tx_q[0];
    assign unused_bits  = ^{sel_q[SEL_W-1:1], tx_q[TX_W-1:1], rx_q[0]};

    bus_serialiser #(.W(SEL_W)) u_sel (
        .clk       (clk),
        .reset     (reset),
        .load      (sel_load),
        .load_data ({lat_slave, SEL_START}),
        .len       (SEL_LEN),
        .shift     (sel_shift),
        .shift_in  (1'b0),
        .data      (sel_q),
        .last      (sel_last)
    );

    bus_serialiser #(.W(TX_W)) u_tx (
        .clk       (clk),
        .reset     (reset),
        .load      (tx_load),
        .load_data (tx_load_data),
        .len       (tx_len),
        .shift     (tx_shift),
        .shift_in  (1'b0),
        .data      (tx_q),
        .last      (tx_last)
    );

    bus_serialiser #(.W(DATA_W)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .load      (rx_load),
        .load_data ('0),
        .len       (RX_LEN),
        .shift     (rx_shift),
        .shift_in  (m_rx),
        .data      (rx_q),
        .last      (rx_last)
    );

endmodule
